control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
//  Main control unit of the 16-bit single-issue RISC core. Decodes the 4-bit opcode plus mode bit and
//  resolves branches from ALU flags ZF/NF. Drives every datapath mux select, ALU op, memory strobe and
//  write-back select. Outputs are registered: one clk of latency between decode inputs and control word.
// PARAMETERS
//  none (all field widths fixed by the ISA)
// PORTS
//  clk        in   1   system clock, rising edge
//  rst        in   1   synchronous, active-high reset
//  cu_enable  in   1   1 = decode this cycle; 0 = issue bubble
//  PC         in   16  current PC; reserved, must not affect outputs
//  opcode     in   4   instruction opcode
//  mode       in   1   LB: 1=signed; branches: 1=compare against zero
//  ZF, NF     in   1   ALU zero / negative (result bit 15) flags, same cycle
//  SrcPc      out  2   next PC: 00 PC+1, 01 branch target, 10 jump target, 11 return addr (BusA)
//  SrcRW      out  1   write reg: 0 Rd, 1 R7
//  SrcRB      out  1   read port B: 0 Rt, 1 Rd
//  SrcRA      out  1   read port A: 0 Rs, 1 R7
//  RegW       out  1   register-file write enable
//  SrcA       out  1   ALU op1: 0 BusA, 1 16'h0000
//  SrcB       out  1   ALU op2: 0 BusB, 1 extended immediate
//  ALUOp      out  2   00 AND, 01 ADD, 10 SUB (op1-op2), 11 unused
//  MemAddSrc  out  1   mem address: 0 ALU result, 1 BusA
//  DataInSrc  out  1   mem write data: 0 BusB, 1 extended immediate
//  MemW, MemR out  1   data-memory write / read strobes
//  WB         out  2   write-back: 00 ALU, 01 mem word, 10 mem byte, 11 PC+1
//  TakeExt1   out  1   immediate extension: 1 sign, 0 zero
//  TakeExt2   out  1   loaded-byte extension: 1 sign, 0 zero
//  byte_en    out  1   byte-wide memory access
// BEHAVIOUR
//  - Rising clk: rst=1 -> all outputs 0 (SrcPc=00, no writes); rst has priority over cu_enable.
//    Else cu_enable=0 -> all outputs 0 (bubble). Else outputs <= decode(opcode,mode,ZF,NF).
//  - Any field not listed for an opcode is 0.
//  - 0000 AND / 0001 ADD / 0010 SUB: RegW=1, ALUOp=00/01/10, WB=00.
//  - 0011 ANDI: RegW=1, SrcB=1, TakeExt1=0, ALUOp=00.  0100 ADDI: same but TakeExt1=1, ALUOp=01.
//  - 0101 LW: RegW, SrcB, TakeExt1, ALUOp=01, MemR, WB=01.
//  - 0110 LB: as LW but WB=10, byte_en=1, TakeExt2=mode.
//  - 0111 SW: SrcB, TakeExt1, ALUOp=01, SrcRB=1, MemW.
//  - 1000-1011 branches: SrcRB=1, ALUOp=10, TakeExt1=1, SrcA=mode (ALU = Rs-Rd or 0-Rd).
//    Taken -> SrcPc=01, else 00. BGT(Z) 1000: NF. BLT(Z) 1001: !NF & !ZF. BEQ(Z) 1010: ZF.
//    BNE(Z) 1011: !ZF. Flags sampled at the same edge that registers the decode.
//  - 1100 JMP: SrcPc=10.  1101 CALL: SrcPc=10, RegW, SrcRW=1, WB=11.  1110 RET: SrcPc=11, SrcRA=1.
//  - 1111 Sv: MemW, MemAddSrc=1, DataInSrc=1, TakeExt1=1 (mem[Rs] <= ext(imm)).
//  - ZF/NF ignored for non-branch opcodes; never MemR and MemW together.
// CONFIGURATION
//  CU_STRICT_DECODE_EN defined: mode=1 with any opcode other than 0110, 1000-1011 decodes as a bubble
//  (all outputs 0). Undefined: mode ignored for those opcodes.
// TESTING
//  - rst=1 for 2 clks with opcode=0101 -> all outputs 0; release -> next edge MemR=1, WB=01.
//  - opcode=0001, cu_enable=1 -> next edge RegW=1, ALUOp=01, SrcB=0; then cu_enable=0 -> all 0.
//  - opcode=0110 mode=1 -> byte_en=1, TakeExt2=1, WB=10; mode=0 -> TakeExt2=0.
//  - 1000 mode=1 NF=1 -> SrcPc=01, SrcA=1; 1001 ZF=0 NF=0 -> 01; 1010 ZF=1 -> 01; 1011 ZF=1 -> 00.
//  - 1101 -> SrcPc=10, RegW=1, SrcRW=1, WB=11; 1110 -> SrcPc=11, SrcRA=1, RegW=0.
//  - 1111 -> MemW=1, MemAddSrc=1, DataInSrc=1; 0000 mode=1 with CU_STRICT_DECODE_EN -> RegW=0.

Source files
------------

// File: rtl/control_unit_if.sv
// Control unit bus: decode inputs (enable, PC, opcode, mode, ALU flags)
// and the registered control word that drives the datapath.
interface control_unit_if;
    logic        cu_enable;
    logic [15:0] PC;
    logic [3:0]  opcode;
    logic        mode;
    logic        ZF;
    logic        NF;

    logic [1:0]  SrcPc;
    logic        SrcRW;
    logic        SrcRB;
    logic        SrcRA;
    logic        RegW;
    logic        SrcA;
    logic        SrcB;
    logic [1:0]  ALUOp;
    logic        MemAddSrc;
    logic        DataInSrc;
    logic        MemW;
    logic        MemR;
    logic [1:0]  WB;
    logic        TakeExt1;
    logic        TakeExt2;
    logic        byte_en;

    // Master side: the pipeline stage that feeds decode inputs and consumes controls
    modport master (
        output cu_enable, PC, opcode, mode, ZF, NF,
        input  SrcPc, SrcRW, SrcRB, SrcRA, RegW, SrcA, SrcB, ALUOp,
               MemAddSrc, DataInSrc, MemW, MemR, WB, TakeExt1, TakeExt2, byte_en
    );

    // Slave side: the control unit itself
    modport slave (
        input  cu_enable, PC, opcode, mode, ZF, NF,
        output SrcPc, SrcRW, SrcRB, SrcRA, RegW, SrcA, SrcB, ALUOp,
               MemAddSrc, DataInSrc, MemW, MemR, WB, TakeExt1, TakeExt2, byte_en
    );
endinterface

// File: rtl/control_unit.sv
// Main control unit of the 16-bit single-issue RISC core.
// Decodes opcode/mode, resolves branches from ZF/NF and registers the
// complete control word (one clock of latency).
// Optional feature macro: CU_STRICT_DECODE_EN -- when defined, mode=1 on any
// opcode that does not use the mode bit (everything but LB and branches)
// is treated as an illegal encoding and issues a bubble.
module control_unit (
    input  logic          clk,
    input  logic          rst,
    control_unit_if.slave bus
);
    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_SUB  = 4'b0010,
        OP_ANDI = 4'b0011,
        OP_ADDI = 4'b0100,
        OP_LW   = 4'b0101,
        OP_LB   = 4'b0110,
        OP_SW   = 4'b0111,
        OP_BGT  = 4'b1000,
        OP_BLT  = 4'b1001,
        OP_BEQ  = 4'b1010,
        OP_BNE  = 4'b1011,
        OP_JMP  = 4'b1100,
        OP_CALL = 4'b1101,
        OP_RET  = 4'b1110,
        OP_SV   = 4'b1111
    } opcode_e;

    typedef struct packed {
        logic [1:0] SrcPc;
        logic       SrcRW;
        logic       SrcRB;
        logic       SrcRA;
        logic       RegW;
        logic       SrcA;
        logic       SrcB;
        logic [1:0] ALUOp;
        logic       MemAddSrc;
        logic       DataInSrc;
        logic       MemW;
        logic       MemR;
        logic [1:0] WB;
        logic       TakeExt1;
        logic       TakeExt2;
        logic       byte_en;
    } ctrl_t;

    opcode_e w_op;
    ctrl_t   w_decode;
    ctrl_t   r_ctrl;
    logic    w_taken;
    logic    w_bubble;
    logic    w_unusedPc;

    assign w_op = opcode_e'(bus.opcode);

    // PC is reserved on this interface; it is deliberately kept out of the decode
    assign w_unusedPc = ^bus.PC;

`ifdef CU_STRICT_DECODE_EN
    assign w_bubble = !bus.cu_enable ||
                      (bus.mode && !((w_op == OP_LB) || (bus.opcode[3:2] == 2'b10)));
`else
    assign w_bubble = !bus.cu_enable;
`endif

    // Branch condition from the flags present at this edge
    always_comb begin
        w_taken = 1'b0;
        case (w_op)
            OP_BGT:  w_taken = bus.NF;
            OP_BLT:  w_taken = !bus.NF && !bus.ZF;
            OP_BEQ:  w_taken = bus.ZF;
            OP_BNE:  w_taken = !bus.ZF;
            default: w_taken = 1'b0;
        endcase
    end

    // Opcode decode into a control word; unlisted fields stay zero
    always_comb begin
        w_decode = '0;
        case (w_op)
            OP_AND: begin
                w_decode.RegW  = 1'b1;
                w_decode.ALUOp = 2'b00;
            end
            OP_ADD: begin
                w_decode.RegW  = 1'b1;
                w_decode.ALUOp = 2'b01;
            end
            OP_SUB: begin
                w_decode.RegW  = 1'b1;
                w_decode.ALUOp = 2'b10;
            end
            OP_ANDI: begin
                w_decode.RegW  = 1'b1;
                w_decode.SrcB  = 1'b1;
                w_decode.ALUOp = 2'b00;
            end
            OP_ADDI: begin
                w_decode.RegW     = 1'b1;
                w_decode.SrcB     = 1'b1;
                w_decode.TakeExt1 = 1'b1;
                w_decode.ALUOp    = 2'b01;
            end
            OP_LW: begin
                w_decode.RegW     = 1'b1;
                w_decode.SrcB     = 1'b1;
                w_decode.TakeExt1 = 1'b1;
                w_decode.ALUOp    = 2'b01;
                w_decode.MemR     = 1'b1;
                w_decode.WB       = 2'b01;
            end
            OP_LB: begin
                w_decode.RegW     = 1'b1;
                w_decode.SrcB     = 1'b1;
                w_decode.TakeExt1 = 1'b1;
                w_decode.ALUOp    = 2'b01;
                w_decode.MemR     = 1'b1;
                w_decode.WB       = 2'b10;
                w_decode.byte_en  = 1'b1;
                w_decode.TakeExt2 = bus.mode;
            end
            OP_SW: begin
                w_decode.SrcB     = 1'b1;
                w_decode.TakeExt1 = 1'b1;
                w_decode.ALUOp    = 2'b01;
                w_decode.SrcRB    = 1'b1;
                w_decode.MemW     = 1'b1;
            end
            OP_BGT, OP_BLT, OP_BEQ, OP_BNE: begin
                w_decode.SrcRB    = 1'b1;
                w_decode.ALUOp    = 2'b10;
                w_decode.TakeExt1 = 1'b1;
                w_decode.SrcA     = bus.mode;
                w_decode.SrcPc    = w_taken ? 2'b01 : 2'b00;
            end
            OP_JMP: begin
                w_decode.SrcPc = 2'b10;
            end
            OP_CALL: begin
                w_decode.SrcPc = 2'b10;
                w_decode.RegW  = 1'b1;
                w_decode.SrcRW = 1'b1;
                w_decode.WB    = 2'b11;
            end
            OP_RET: begin
                w_decode.SrcPc = 2'b11;
                w_decode.SrcRA = 1'b1;
            end
            OP_SV: begin
                w_decode.MemW      = 1'b1;
                w_decode.MemAddSrc = 1'b1;
                w_decode.DataInSrc = 1'b1;
                w_decode.TakeExt1  = 1'b1;
            end
            default: w_decode = '0;
        endcase
    end

    // Control word register: reset wins, then bubbles, then the decoded word
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl <= '0;
        end else if (w_bubble) begin
            r_ctrl <= '0;
        end else begin
            r_ctrl <= w_decode;
        end
    end

    assign bus.SrcPc     = r_ctrl.SrcPc;
    assign bus.SrcRW     = r_ctrl.SrcRW;
    assign bus.SrcRB     = r_ctrl.SrcRB;
    assign bus.SrcRA     = r_ctrl.SrcRA;
    assign bus.RegW      = r_ctrl.RegW;
    assign bus.SrcA      = r_ctrl.SrcA;
    assign bus.SrcB      = r_ctrl.SrcB;
    assign bus.ALUOp     = r_ctrl.ALUOp;
    assign bus.MemAddSrc = r_ctrl.MemAddSrc;
    assign bus.DataInSrc = r_ctrl.DataInSrc;
    assign bus.MemW      = r_ctrl.MemW;
    assign bus.MemR      = r_ctrl.MemR;
    assign bus.WB        = r_ctrl.WB;
    assign bus.TakeExt1  = r_ctrl.TakeExt1;
    assign bus.TakeExt2  = r_ctrl.TakeExt2;
    assign bus.byte_en   = r_ctrl.byte_en;
endmodule

// File: tb/tb_control_unit.sv
// Testbench for control_unit: directed vector table, a few hand-written
// multi-cycle sequences, then randomized decode against a per-output model.
module tb_control_unit;
    typedef struct packed {
        logic [1:0] SrcPc;
        logic       SrcRW;
        logic       SrcRB;
        logic       SrcRA;
        logic       RegW;
        logic       SrcA;
        logic       SrcB;
        logic [1:0] ALUOp;
        logic       MemAddSrc;
        logic       DataInSrc;
        logic       MemW;
        logic       MemR;
        logic [1:0] WB;
        logic       TakeExt1;
        logic       TakeExt2;
        logic       byte_en;
    } ctrl_t;

    typedef struct packed {
        logic       rst;
        logic       en;
        logic [3:0] opcode;
        logic       mode;
        logic       zf;
        logic       nf;
        ctrl_t      exp;
    } vec_t;

    logic  clk;
    logic  rst;
    int    checks;
    int    errors;
    vec_t  vecs[$];
    ctrl_t e;

    control_unit_if bus ();

    control_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each output expressed as a predicate over opcode classes
    function automatic ctrl_t refModel(input logic r, input logic en, input logic [3:0] op,
                                       input logic m, input logic zf, input logic nf);
        ctrl_t c;
        int    o;
        logic  isBr;
        logic  taken;
        c = '0;
        o = int'(op);
        if (r || !en) return c;
`ifdef CU_STRICT_DECODE_EN
        if (m && !(o == 6 || (o >= 8 && o <= 11))) return c;
`endif
        isBr  = (o >= 8 && o <= 11);
        taken = (o == 8)  ? nf :
                (o == 9)  ? (!nf && !zf) :
                (o == 10) ? zf : !zf;
        c.SrcPc     = isBr ? (taken ? 2'd1 : 2'd0) :
                      (o == 12 || o == 13) ? 2'd2 :
                      (o == 14) ? 2'd3 : 2'd0;
        c.SrcRW     = (o == 13);
        c.SrcRB     = isBr || (o == 7);
        c.SrcRA     = (o == 14);
        c.RegW      = (o <= 6) || (o == 13);
        c.SrcA      = isBr && m;
        c.SrcB      = (o >= 3 && o <= 7);
        c.ALUOp     = (o == 1 || (o >= 4 && o <= 7)) ? 2'd1 :
                      (o == 2 || isBr) ? 2'd2 : 2'd0;
        c.MemAddSrc = (o == 15);
        c.DataInSrc = (o == 15);
        c.MemW      = (o == 7) || (o == 15);
        c.MemR      = (o == 5) || (o == 6);
        c.WB        = (o == 5) ? 2'd1 : (o == 6) ? 2'd2 : (o == 13) ? 2'd3 : 2'd0;
        c.TakeExt1  = (o >= 4 && o <= 7) || isBr || (o == 15);
        c.TakeExt2  = (o == 6) && m;
        c.byte_en   = (o == 6);
        return c;
    endfunction

    task automatic addVec(input logic r, input logic en, input logic [3:0] op,
                          input logic m, input logic zf, input logic nf, input ctrl_t x);
        vec_t v;
        v.rst = r; v.en = en; v.opcode = op; v.mode = m; v.zf = zf; v.nf = nf; v.exp = x;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, then move to just after the registering edge
    task automatic applyStimulus(input logic r, input logic en, input logic [3:0] op,
                                 input logic m, input logic zf, input logic nf);
        rst           = r;
        bus.cu_enable = en;
        bus.opcode    = op;
        bus.mode      = m;
        bus.ZF        = zf;
        bus.NF        = nf;
        bus.PC        = 16'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input ctrl_t expected);
        ctrl_t actual;
        actual = {bus.SrcPc, bus.SrcRW, bus.SrcRB, bus.SrcRA, bus.RegW, bus.SrcA, bus.SrcB,
                  bus.ALUOp, bus.MemAddSrc, bus.DataInSrc, bus.MemW, bus.MemR, bus.WB,
                  bus.TakeExt1, bus.TakeExt2, bus.byte_en};
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %05h expected %05h", name, actual, expected);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.cu_enable = 1'b0; bus.opcode = 4'b0; bus.mode = 1'b0;
        bus.ZF = 1'b0; bus.NF = 1'b0; bus.PC = 16'h0;

        // Directed vector table; rows are applied back to back, one per clock
        e = '0;
        addVec(1, 1, 4'b0101, 0, 0, 0, e);
        addVec(1, 1, 4'b0101, 0, 0, 0, e);
        e = '0; e.RegW = 1; e.SrcB = 1; e.TakeExt1 = 1; e.ALUOp = 2'b01; e.MemR = 1; e.WB = 2'b01;
        addVec(0, 1, 4'b0101, 0, 0, 0, e);
        e = '0; e.RegW = 1; e.ALUOp = 2'b01;
        addVec(0, 1, 4'b0001, 0, 1, 1, e);
        e = '0;
        addVec(0, 0, 4'b0001, 0, 0, 0, e);
        e = '0; e.RegW = 1; e.SrcB = 1; e.TakeExt1 = 1; e.ALUOp = 2'b01; e.MemR = 1;
        e.WB = 2'b10; e.byte_en = 1; e.TakeExt2 = 1;
        addVec(0, 1, 4'b0110, 1, 0, 0, e);
        e.TakeExt2 = 0;
        addVec(0, 1, 4'b0110, 0, 0, 0, e);
        e = '0; e.SrcRB = 1; e.ALUOp = 2'b10; e.TakeExt1 = 1; e.SrcA = 1; e.SrcPc = 2'b01;
        addVec(0, 1, 4'b1000, 1, 0, 1, e);
        e.SrcA = 0;
        addVec(0, 1, 4'b1001, 0, 0, 0, e);
        addVec(0, 1, 4'b1010, 0, 1, 0, e);
        e.SrcPc = 2'b00;
        addVec(0, 1, 4'b1011, 0, 1, 0, e);
        addVec(0, 1, 4'b1000, 0, 0, 0, e);
        e = '0; e.SrcPc = 2'b10; e.RegW = 1; e.SrcRW = 1; e.WB = 2'b11;
        addVec(0, 1, 4'b1101, 0, 0, 0, e);
        e = '0; e.SrcPc = 2'b11; e.SrcRA = 1;
        addVec(0, 1, 4'b1110, 0, 0, 0, e);
        e = '0; e.MemW = 1; e.MemAddSrc = 1; e.DataInSrc = 1; e.TakeExt1 = 1;
        addVec(0, 1, 4'b1111, 0, 0, 0, e);
        e = '0; e.SrcB = 1; e.TakeExt1 = 1; e.ALUOp = 2'b01; e.SrcRB = 1; e.MemW = 1;
        addVec(0, 1, 4'b0111, 0, 0, 0, e);
        e = '0; e.RegW = 1; e.SrcB = 1;
        addVec(0, 1, 4'b0011, 0, 0, 0, e);
        e = '0; e.RegW = 1; e.SrcB = 1; e.TakeExt1 = 1; e.ALUOp = 2'b01;
        addVec(0, 1, 4'b0100, 0, 0, 0, e);
        e = '0; e.RegW = 1; e.ALUOp = 2'b10;
        addVec(0, 1, 4'b0010, 0, 0, 0, e);
        e = '0; e.SrcPc = 2'b10;
        addVec(0, 1, 4'b1100, 0, 1, 1, e);
        e = '0;
`ifndef CU_STRICT_DECODE_EN
        e.RegW = 1;
`endif
        addVec(0, 1, 4'b0000, 1, 0, 0, e);
        e = '0;
        addVec(1, 1, 4'b0001, 0, 0, 0, e);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].opcode,
                          vecs[i].mode, vecs[i].zf, vecs[i].nf);
            checkOutput($sformatf("vec%0d_op%b", i, vecs[i].opcode), vecs[i].exp);
        end

        // Flags are taken from the very edge that registers the branch
        e = '0; e.SrcRB = 1; e.ALUOp = 2'b10; e.TakeExt1 = 1;
        applyStimulus(0, 1, 4'b1010, 0, 0, 1);
        checkOutput("seq_beq_not_taken", e);
        e.SrcPc = 2'b01;
        applyStimulus(0, 1, 4'b1010, 0, 1, 0);
        checkOutput("seq_beq_taken", e);
        e = '0; e.RegW = 1; e.ALUOp = 2'b01;
        applyStimulus(0, 1, 4'b0001, 0, 1, 1);
        checkOutput("seq_add_flags_ignored", e);
        e = '0;
        applyStimulus(0, 0, 4'b1101, 0, 0, 0);
        checkOutput("seq_bubble_after_add", e);
        e = '0; e.SrcPc = 2'b10; e.RegW = 1; e.SrcRW = 1; e.WB = 2'b11;
        applyStimulus(0, 1, 4'b1101, 0, 0, 0);
        checkOutput("seq_call_after_bubble", e);

        // Randomized decode against the reference model
        for (int n = 0; n < 400; n++) begin
            logic       r, en, m, zf, nf;
            logic [3:0] op;
            r  = ($urandom_range(15) == 0);
            en = ($urandom_range(3) != 0);
            op = 4'($urandom);
            m  = 1'($urandom);
            zf = 1'($urandom);
            nf = 1'($urandom);
            applyStimulus(r, en, op, m, zf, nf);
            checkOutput($sformatf("rand%0d_op%b_m%b_z%b_n%b", n, op, m, zf, nf),
                        refModel(r, en, op, m, zf, nf));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
